univ_shift_reg: RTL

Clocked, parametrised successor to the team's level-sensitive parallel-load register.
- Edge-triggered N-bit register with eight operating modes: hold, load, logical shifts, rotates, arithmetic shift and clear.
- Built-in auto-serialiser: loads a word and shifts it out bit-by-bit over N enabled cycles, with busy/done status.
- Used as a general data register and as a parallel-to-serial converter in front of serial links.

---
 rtl/univ_shift_reg_if.sv | 31 +++
 rtl/univ_shift_reg.sv | 95 +++++++++
 2 files changed

// File: rtl/univ_shift_reg_if.sv
// Bus bundle for univ_shift_reg: control and data inputs plus register/serial
// outputs. The N parameter here must match the N of the attached register.
//
// Handshake: there is no valid/ready pair. start is a request sampled on a
// rising edge only while busy is low; a start seen while busy is high is
// dropped. busy rises on the edge that accepts start and falls on the edge
// that raises done. done is a one-cycle pulse. en qualifies every shift.
interface univ_shift_reg_if #(
  parameter int N = 12
);
  logic         en;
  logic [2:0]   mode;
  logic [N-1:0] di;
  logic         si;
  logic         start;
  logic         dir;
  logic [N-1:0] q;
  logic         so;
  logic         busy;
  logic         done;

  modport master (
    output en, mode, di, si, start, dir,
    input  q, so, busy, done
  );

  modport slave (
    input  en, mode, di, si, start, dir,
    output q, so, busy, done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal N-bit shift register with eight manual modes and an
// auto-serialiser that shifts a loaded word out over N enabled cycles.
module univ_shift_reg #(
  parameter int N = 12,
  localparam int CW = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  univ_shift_reg_if.slave   bus,
  output logic              dbg_state_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROTL  = 3'b100;
  localparam logic [2:0] M_ROTR  = 3'b101;
  localparam logic [2:0] M_ASHR  = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  // Counter value on the final auto shift.
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state_q;
  logic [N-1:0]   q_q;
  logic [CW-1:0]  cnt_q;
  logic           dir_q;
  logic           busy_q;
  logic           done_q;

  // Single-process FSM: manual ops in IDLE, auto-serialise in SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            // start wins over mode and needs no enable.
            q_q     <= bus.di;
            dir_q   <= bus.dir;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end else if (bus.en) begin
            case (bus.mode)
              M_HOLD:  q_q <= q_q;
              M_LOAD:  q_q <= bus.di;
              M_SHL:   q_q <= {q_q[N-2:0], bus.si};
              M_SHR:   q_q <= {bus.si, q_q[N-1:1]};
              M_ROTL:  q_q <= {q_q[N-2:0], q_q[N-1]};
              M_ROTR:  q_q <= {q_q[0], q_q[N-1:1]};
              M_ASHR:  q_q <= {q_q[N-1], q_q[N-1:1]};
              M_CLEAR: q_q <= '0;
              default: q_q <= q_q;
            endcase
          end
        end
        ST_SHIFT: begin
          // mode and start are ignored here; en = 0 pauses everything.
          if (bus.en) begin
            q_q   <= dir_q ? {bus.si, q_q[N-1:1]} : {q_q[N-2:0], bus.si};
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Serial output taps the end that leaves first in the latched direction.
  assign bus.so      = dir_q ? q_q[0] : q_q[N-1];
  assign bus.q       = q_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign dbg_state_o = state_q;

endmodule
